// File: rtl/mac_dma_engine.sv
// rtl/mac_dma_engine.sv - chunked multiply-accumulate engine on a DMA32/DMA64 accelerator socket
// Reads (a,b) pairs per chunk, buffers one 32-bit sum per vector, writes each chunk back in one burst.
module mac_dma_engine #(
   parameter int DMA_WIDTH = 32,
   parameter int MAX_VEC   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          conf_info_mac_n,
   input  logic [31:0]          conf_info_mac_vec,
   input  logic [31:0]          conf_info_mac_len,
   input  logic                 conf_done,
   output logic                 acc_done,
   output logic [31:0]          debug,
   output logic                 dma_read_ctrl_valid,
   input  logic                 dma_read_ctrl_ready,
   output logic [31:0]          dma_read_ctrl_data_index,
   output logic [31:0]          dma_read_ctrl_data_length,
   output logic [2:0]           dma_read_ctrl_data_size,
   input  logic                 dma_read_chnl_valid,
   output logic                 dma_read_chnl_ready,
   input  logic [DMA_WIDTH-1:0] dma_read_chnl_data,
   output logic                 dma_write_ctrl_valid,
   input  logic                 dma_write_ctrl_ready,
   output logic [31:0]          dma_write_ctrl_data_index,
   output logic [31:0]          dma_write_ctrl_data_length,
   output logic [2:0]           dma_write_ctrl_data_size,
   output logic                 dma_write_chnl_valid,
   input  logic                 dma_write_chnl_ready,
   output logic [DMA_WIDTH-1:0] dma_write_chnl_data
);

   localparam int          WPB   = DMA_WIDTH / 32;
   localparam int          SH    = (WPB == 2) ? 1 : 0;
   localparam int          AW    = (MAX_VEC > 1) ? $clog2(MAX_VEC) : 1;
   localparam logic [31:0] WPB32 = WPB;
   localparam logic [2:0]  SIZE  = (DMA_WIDTH == 64) ? 3'b011 : 3'b010;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_REQ,
      S_RD_DATA,
      S_WR_REQ,
      S_WR_DATA,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] n_q, n_d, vec_q, vec_d, len_q, len_d;
   logic [31:0] rd_len_q, rd_len_d, wr_len_q, wr_len_d;
   logic [31:0] rd_idx_q, rd_idx_d, wr_idx_q, wr_idx_d;
   logic [31:0] c_q, c_d, v_q, v_d, p_q, p_d, k_q, k_d, wb_q, wb_d;
   logic [31:0] acc_q, acc_d, a_q, a_d;
   logic        phase_q, phase_d, debug_q, debug_d;

   logic [31:0] res_q [MAX_VEC];
   logic        res_we;

   logic                 rd_beat, pair_done;
   logic [31:0]          op_a, op_b, prod, acc_sum;
   logic [DMA_WIDTH-1:0] wr_beat;
   logic                 cfg_err;
   logic [31:0]          cfg_rl, cfg_wl, cfg_wbase;

   assign rd_beat = (state_q == S_RD_DATA) && dma_read_chnl_valid;

   // DMA64 carries a whole pair per beat; DMA32 needs a then b on consecutive beats
   if (DMA_WIDTH == 64) begin : g_w64
      logic [31:0] k1;
      logic [31:0] hi_word;
      assign pair_done = rd_beat;
      assign op_a      = dma_read_chnl_data[31:0];
      assign op_b      = dma_read_chnl_data[DMA_WIDTH-1:32];
      assign k1        = k_q + 32'd1;
      assign hi_word   = (k1 < vec_q) ? res_q[k1[AW-1:0]] : 32'd0;
      assign wr_beat   = {hi_word, res_q[k_q[AW-1:0]]};
   end else begin : g_w32
      assign pair_done = rd_beat && phase_q;
      assign op_a      = a_q;
      assign op_b      = dma_read_chnl_data[31:0];
      assign wr_beat   = res_q[k_q[AW-1:0]];
   end

   assign prod    = op_a * op_b;
   assign acc_sum = acc_q + prod;

   assign cfg_err   = (conf_info_mac_n == 32'd0) || (conf_info_mac_vec == 32'd0) ||
                      (conf_info_mac_len == 32'd0) || (conf_info_mac_vec > 32'(MAX_VEC));
   assign cfg_rl    = ((conf_info_mac_vec * conf_info_mac_len) << 1) >> SH;
   assign cfg_wl    = (conf_info_mac_vec + WPB32 - 32'd1) >> SH;
   assign cfg_wbase = conf_info_mac_n * cfg_rl;

   always_comb begin
      state_d  = state_q;
      n_d      = n_q;
      vec_d    = vec_q;
      len_d    = len_q;
      rd_len_d = rd_len_q;
      wr_len_d = wr_len_q;
      rd_idx_d = rd_idx_q;
      wr_idx_d = wr_idx_q;
      c_d      = c_q;
      v_d      = v_q;
      p_d      = p_q;
      k_d      = k_q;
      wb_d     = wb_q;
      acc_d    = acc_q;
      a_d      = a_q;
      phase_d  = phase_q;
      debug_d  = debug_q;
      res_we   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (conf_done) begin
               n_d   = conf_info_mac_n;
               vec_d = conf_info_mac_vec;
               len_d = conf_info_mac_len;
               if (cfg_err) begin
                  debug_d = 1'b1;
                  state_d = S_DONE;
               end else begin
                  debug_d  = 1'b0;
                  rd_len_d = cfg_rl;
                  wr_len_d = cfg_wl;
                  rd_idx_d = 32'd0;
                  wr_idx_d = cfg_wbase;
                  c_d      = 32'd0;
                  state_d  = S_RD_REQ;
               end
            end
         end
         S_RD_REQ: begin
            if (dma_read_ctrl_ready) begin
               v_d     = 32'd0;
               p_d     = 32'd0;
               phase_d = 1'b0;
               acc_d   = 32'd0;
               state_d = S_RD_DATA;
            end
         end
         S_RD_DATA: begin
            if (rd_beat) begin
               a_d     = dma_read_chnl_data[31:0];
               phase_d = ~phase_q;
            end
            if (pair_done) begin
               phase_d = 1'b0;
               if (p_q == len_q - 32'd1) begin
                  res_we = 1'b1;
                  acc_d  = 32'd0;
                  p_d    = 32'd0;
                  v_d    = v_q + 32'd1;
                  if (v_q == vec_q - 32'd1) begin
                     k_d     = 32'd0;
                     wb_d    = 32'd0;
                     state_d = S_WR_REQ;
                  end
               end else begin
                  acc_d = acc_sum;
                  p_d   = p_q + 32'd1;
               end
            end
         end
         S_WR_REQ: begin
            if (dma_write_ctrl_ready) state_d = S_WR_DATA;
         end
         S_WR_DATA: begin
            if (dma_write_chnl_ready) begin
               k_d  = k_q + WPB32;
               wb_d = wb_q + 32'd1;
               if (wb_q == wr_len_q - 32'd1) begin
                  c_d      = c_q + 32'd1;
                  rd_idx_d = rd_idx_q + rd_len_q;
                  wr_idx_d = wr_idx_q + wr_len_q;
                  state_d  = (c_q + 32'd1 == n_q) ? S_DONE : S_RD_REQ;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         n_q      <= '0;
         vec_q    <= '0;
         len_q    <= '0;
         rd_len_q <= '0;
         wr_len_q <= '0;
         rd_idx_q <= '0;
         wr_idx_q <= '0;
         c_q      <= '0;
         v_q      <= '0;
         p_q      <= '0;
         k_q      <= '0;
         wb_q     <= '0;
         acc_q    <= '0;
         a_q      <= '0;
         phase_q  <= 1'b0;
         debug_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         n_q      <= n_d;
         vec_q    <= vec_d;
         len_q    <= len_d;
         rd_len_q <= rd_len_d;
         wr_len_q <= wr_len_d;
         rd_idx_q <= rd_idx_d;
         wr_idx_q <= wr_idx_d;
         c_q      <= c_d;
         v_q      <= v_d;
         p_q      <= p_d;
         k_q      <= k_d;
         wb_q     <= wb_d;
         acc_q    <= acc_d;
         a_q      <= a_d;
         phase_q  <= phase_d;
         debug_q  <= debug_d;
      end
   end

   // Result storage needs no reset: every slot read back is written earlier in the same chunk
   always_ff @(posedge clk) begin
      if (res_we) res_q[v_q[AW-1:0]] <= acc_sum;
   end

   assign acc_done = (state_q == S_DONE);
   assign debug    = {31'd0, debug_q};

   assign dma_read_ctrl_valid        = (state_q == S_RD_REQ);
   assign dma_read_ctrl_data_index   = dma_read_ctrl_valid ? rd_idx_q : 32'd0;
   assign dma_read_ctrl_data_length  = dma_read_ctrl_valid ? rd_len_q : 32'd0;
   assign dma_read_ctrl_data_size    = dma_read_ctrl_valid ? SIZE : 3'b000;
   assign dma_read_chnl_ready        = (state_q == S_RD_DATA);

   assign dma_write_ctrl_valid       = (state_q == S_WR_REQ);
   assign dma_write_ctrl_data_index  = dma_write_ctrl_valid ? wr_idx_q : 32'd0;
   assign dma_write_ctrl_data_length = dma_write_ctrl_valid ? wr_len_q : 32'd0;
   assign dma_write_ctrl_data_size   = dma_write_ctrl_valid ? SIZE : 3'b000;
   assign dma_write_chnl_valid       = (state_q == S_WR_DATA);
   assign dma_write_chnl_data        = dma_write_chnl_valid ? wr_beat : '0;

endmodule
